// File: rtl/sprite_fetch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// sprite_fetch_arbiter_pkg : shared sizes, texel types and address helper
// Revision : 1.0
// ============================================================================
package sprite_fetch_arbiter_pkg;

  localparam int NUM_REQ = 5;
  localparam int SPR_W   = 64;
  localparam int SPR_H   = 64;
  localparam int FRAME_W = 3;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 24;

  localparam int X_W       = $clog2(SPR_W);
  localparam int Y_W       = $clog2(SPR_H);
  localparam int ID_W      = $clog2(NUM_REQ);
  localparam int ADDR_USED = FRAME_W + Y_W + X_W;

  typedef logic [DATA_W-1:0] texel_t;
  typedef logic [ID_W-1:0]   req_id_t;

  localparam texel_t TRANSP_KEY = 24'hFF00FF;

  // Power-of-two sprite sizes make frame*W*H + y*W + x a plain concatenation.
  function automatic logic [ADDR_W-1:0] sprite_addr(
    input logic [FRAME_W-1:0] frame,
    input logic [X_W-1:0]     x,
    input logic [Y_W-1:0]     y
  );
    logic [ADDR_USED-1:0] w_lin;
    w_lin = {frame, y, x};
    return ADDR_W'(w_lin);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_fetch_arbiter_if.sv
`default_nettype none
// ============================================================================
// sprite_fetch_arbiter_if : lane request, frame RAM and response bundle
// Revision : 1.0
// ============================================================================
interface sprite_fetch_arbiter_if;
  import sprite_fetch_arbiter_pkg::*;

  logic                             arb_en;
  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ-1:0][FRAME_W-1:0]  req_frame;
  logic [NUM_REQ-1:0][X_W-1:0]      req_x;
  logic [NUM_REQ-1:0][Y_W-1:0]      req_y;
  logic [NUM_REQ-1:0]               gnt;
  logic [ADDR_W-1:0]                rom_addr;
  texel_t                           rom_data;
  logic                             rsp_valid;
  req_id_t                          rsp_id;
  texel_t                           rsp_data;
  logic                             rsp_opaque;

  modport slave (
    input  arb_en, req, req_frame, req_x, req_y, rom_data,
    output gnt, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_opaque
  );

  modport master (
    output arb_en, req, req_frame, req_x, req_y, rom_data,
    input  gnt, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_opaque
  );

endinterface
`default_nettype wire

// File: rtl/sprite_fetch_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin arbiter with combinational one-hot grant
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N = 5,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             accepted
);

  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Scan last+1 .. last+N so the most recent winner is considered last.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign accepted = en & w_found & Reset_n;
  assign gnt      = accepted ? (N'(1) << w_idx) : '0;
  assign gnt_idx  = w_idx;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_last <= IDX_W'(N - 1);
    end else if (accepted) begin
      r_last <= w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// sprite_fetch_arbiter : shares one 1-cycle sprite RAM among the note lanes
// Revision : 1.0
// ============================================================================
module sprite_fetch_arbiter
  import sprite_fetch_arbiter_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Reset_n,
  sprite_fetch_arbiter_if.slave  bus
);

  logic [NUM_REQ-1:0] w_gnt;
  req_id_t            w_idx;
  logic               w_accepted;
  logic [ADDR_W-1:0]  w_addr;

  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_s1_valid;
  req_id_t            r_s1_id;
  logic               r_s2_valid;
  req_id_t            r_s2_id;

  if (ADDR_USED > ADDR_W) begin : g_addr_check
    $error("sprite address fields wider than ADDR_W");
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .en       (bus.arb_en),
    .req      (bus.req),
    .gnt      (w_gnt),
    .gnt_idx  (w_idx),
    .accepted (w_accepted)
  );

  assign bus.gnt = w_gnt;
  assign w_addr  = sprite_addr(bus.req_frame[w_idx], bus.req_x[w_idx], bus.req_y[w_idx]);

  // Stage 1 tracks the address cycle, stage 2 the cycle the RAM data appears.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rom_addr <= '0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
    end else begin
      if (w_accepted) begin
        r_rom_addr <= w_addr;
        r_s1_id    <= w_idx;
      end
      r_s1_valid <= w_accepted;
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.rsp_valid  = r_s2_valid;
  assign bus.rsp_id     = r_s2_id;
  // RAM output is passed straight through; gating keeps it quiet when idle.
  assign bus.rsp_data   = r_s2_valid ? bus.rom_data : '0;
  assign bus.rsp_opaque = r_s2_valid && (bus.rom_data != TRANSP_KEY);

endmodule
`default_nettype wire
